resp_packer: RTL and testbench
==============================

RESP_PACKER -- requirements
Module: resp_packer

Interface
REQ-001 SHALL have parameter data_width, default 8, byte width of FIFO words and register-file data.
REQ-002 SHALL have parameter res_width, default 16, ALU result width; always 2*data_width.
REQ-003 SHALL have port clk  input  1  REF_CLK domain clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alu_out  input  res_width  ALU result, qualified by out_valid.
REQ-006 SHALL have port out_valid  input  1  single-cycle ALU result strobe.
REQ-007 SHALL have port rddata  input  data_width  register-file read data, qualified by rddata_valid.
REQ-008 SHALL have port rddata_valid  input  1  single-cycle read-data strobe.
REQ-009 SHALL have port fifo_full  input  1  TX FIFO write-side full flag.
REQ-010 SHALL have port wr_inc  output  1  FIFO write strobe; one byte per asserted cycle.
REQ-011 SHALL have port wr_data  output  data_width  byte presented to the FIFO.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port drop_err  output  1  registered one-cycle pulse when a response is discarded.

Function
REQ-014 SHALL implement FSM states IDLE, SEND_LO, SEND_HI, SEND_RD.
REQ-015 IDLE with out_valid=1: capture alu_out into a res_width holding register; next state SEND_LO.
REQ-016 IDLE with rddata_valid=1 and out_valid=0: capture rddata into the low byte of the holding register; next state SEND_RD.
REQ-017 IDLE with out_valid=1 and rddata_valid=1 in the same cycle: ALU wins; read data discarded; drop_err pulses on the next cycle.
REQ-018 Any strobe arriving while not in IDLE: SHALL be discarded, holding register unchanged, drop_err pulse on the next cycle.
REQ-019 wr_inc SHALL be combinational: 1 iff state is SEND_LO, SEND_HI or SEND_RD and fifo_full=0.
REQ-020 wr_data SHALL be holding[7:0] in SEND_LO and SEND_RD, holding[15:8] in SEND_HI, 0 in IDLE.
REQ-021 Transitions: SEND_LO goes to SEND_HI and SEND_HI goes to IDLE only in a cycle with wr_inc=1; otherwise the state holds.
REQ-022 SEND_RD SHALL return to IDLE only in a cycle with wr_inc=1; otherwise it holds.
REQ-023 fifo_full=1 SHALL stall indefinitely with no byte lost or duplicated; each byte written exactly once.
REQ-024 Latency: strobe in cycle N gives the first wr_inc in cycle N+1 when the FIFO is not full; the ALU result occupies cycles N+1 and N+2.
REQ-025 Back-to-back: a new strobe SHALL be accepted in the same cycle the FSM re-enters IDLE, one cycle after the last write.
REQ-026 Byte order on the FIFO SHALL be low byte first, then high byte.

Reset
REQ-027 reset low SHALL force asynchronously: state IDLE, holding register 0, drop_err 0; hence wr_inc 0, wr_data 0, busy 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the pending bytes; no wr_inc during or after reset until a new strobe arrives.
REQ-029 Deassertion is synchronised externally; no strobe is accepted before the first clk edge after deassertion.

Structure
REQ-030 State encoding (2-bit localparams) and data_width/res_width defaults SHALL live in the shared system package.
REQ-031 SHALL be a single flat module; no sub-module instances.

Verification
REQ-032 Scenario: alu_out=16'hA55A, out_valid in cycle 0, fifo_full=0 -> wr_inc in cycles 1,2 with wr_data 8'h5A then 8'hA5; busy cycles 1-2; drop_err never.
REQ-033 Scenario: rddata=8'h3C, rddata_valid in cycle 0 -> one wr_inc in cycle 1 with wr_data 8'h3C; busy cycle 1 only.
REQ-034 Scenario: alu_out=16'h1234 in cycle 0, fifo_full=1 during cycles 1-4 -> no wr_inc during 1-4; 8'h34 in cycle 5, 8'h12 in cycle 6.
REQ-035 Scenario: out_valid and rddata_valid both in cycle 0 -> only the ALU bytes written; drop_err=1 in cycle 1 only.
REQ-036 Scenario: out_valid in cycle 0, rddata_valid in cycle 1 -> read data dropped; drop_err in cycle 2; ALU bytes written intact.
REQ-037 Scenario: reset low in cycle 1 of a 16'hBEEF transfer -> 8'hEF may already be written in cycle 1; no write of 8'hBE; outputs 0; IDLE after reset release.

Source files
------------

// File: rtl/resp_packer_pkg.sv
// Shared definitions for the response packer: default widths and FSM state encoding.
package resp_packer_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int RES_WIDTH  = 2 * DATA_WIDTH;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEND_LO = 2'd1;
   localparam logic [1:0] ST_SEND_HI = 2'd2;
   localparam logic [1:0] ST_SEND_RD = 2'd3;

endpackage

// File: rtl/resp_packer.sv
// Serialises ALU results (two bytes, low first) and register read data (one byte)
// into a byte-wide TX FIFO, stalling on fifo_full and flagging discarded responses.
module resp_packer
   import resp_packer_pkg::*;
#(
   parameter int data_width = DATA_WIDTH,
   parameter int res_width  = RES_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [res_width-1:0]  alu_out,
   input  logic                  out_valid,
   input  logic [data_width-1:0] rddata,
   input  logic                  rddata_valid,
   input  logic                  fifo_full,
   output logic                  wr_inc,
   output logic [data_width-1:0] wr_data,
   output logic                  busy,
   output logic                  drop_err
);

   logic [1:0]           state, state_nxt;
   logic [res_width-1:0] holding;
   logic                 drop_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (out_valid)         state_nxt = ST_SEND_LO;
            else if (rddata_valid) state_nxt = ST_SEND_RD;
         end
         ST_SEND_LO: if (wr_inc) state_nxt = ST_SEND_HI;
         ST_SEND_HI: if (wr_inc) state_nxt = ST_IDLE;
         ST_SEND_RD: if (wr_inc) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_inc  = 1'b0;
      wr_data = '0;
      busy    = (state != ST_IDLE);
      case (state)
         ST_SEND_LO, ST_SEND_RD: begin
            wr_inc  = !fifo_full;
            wr_data = holding[data_width-1:0];
         end
         ST_SEND_HI: begin
            wr_inc  = !fifo_full;
            wr_data = holding[res_width-1:data_width];
         end
         default: ;
      endcase
   end

   // A strobe is lost if the FSM is busy, or if read data collides with an ALU result.
   assign drop_nxt = (state != ST_IDLE) ? (out_valid || rddata_valid)
                                        : (out_valid && rddata_valid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         holding  <= '0;
         drop_err <= 1'b0;
      end else begin
         drop_err <= drop_nxt;
         if (state == ST_IDLE) begin
            if (out_valid)         holding <= alu_out;
            else if (rddata_valid) holding[data_width-1:0] <= rddata;
         end
      end
   end

endmodule

// File: tb/tb_resp_packer.sv
// Directed bench for resp_packer: a per-cycle vector trace plus a mid-transfer reset sequence.
module tb_resp_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] alu_out;
   logic        out_valid;
   logic [7:0]  rddata;
   logic        rddata_valid;
   logic        fifo_full;
   logic        wr_inc;
   logic [7:0]  wr_data;
   logic        busy;
   logic        drop_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   resp_packer #(.data_width(8), .res_width(16)) dut (
      .clk(clk), .reset(reset), .alu_out(alu_out), .out_valid(out_valid),
      .rddata(rddata), .rddata_valid(rddata_valid), .fifo_full(fifo_full),
      .wr_inc(wr_inc), .wr_data(wr_data), .busy(busy), .drop_err(drop_err)
   );

   typedef struct {
      logic        ov;
      logic        rv;
      logic [15:0] alu;
      logic [7:0]  rd;
      logic        ff;
      logic        e_inc;
      logic [7:0]  e_data;
      logic        e_busy;
      logic        e_drop;
   } vec_t;

   localparam int NV = 26;
   vec_t tbl [NV];

   function automatic vec_t mk(logic ov, logic rv, logic [15:0] alu, logic [7:0] rd, logic ff,
                               logic e_inc, logic [7:0] e_data, logic e_busy, logic e_drop);
      vec_t v;
      v.ov = ov; v.rv = rv; v.alu = alu; v.rd = rd; v.ff = ff;
      v.e_inc = e_inc; v.e_data = e_data; v.e_busy = e_busy; v.e_drop = e_drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_inc, input logic [7:0] e_data,
                          input logic e_busy, input logic e_drop);
      chk({tag, ".wr_inc"},   {15'd0, wr_inc},   {15'd0, e_inc});
      chk({tag, ".wr_data"},  {8'd0, wr_data},   {8'd0, e_data});
      chk({tag, ".busy"},     {15'd0, busy},     {15'd0, e_busy});
      chk({tag, ".drop_err"}, {15'd0, drop_err}, {15'd0, e_drop});
   endtask

   task automatic idle_inputs();
      out_valid = 1'b0; rddata_valid = 1'b0; fifo_full = 1'b0;
      alu_out = 16'h0; rddata = 8'h0;
   endtask

   initial begin
      // Each row is one cycle: inputs driven, then outputs expected during that cycle.
      //             ov rv alu      rd     ff  inc data   busy drop
      tbl[0]  = mk(1, 0, 16'hA55A, 8'h00, 0,  0, 8'h00, 0, 0);
      tbl[1]  = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'h5A, 1, 0);
      tbl[2]  = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'hA5, 1, 0);
      tbl[3]  = mk(0, 1, 16'h0000, 8'h3C, 0,  0, 8'h00, 0, 0);
      tbl[4]  = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'h3C, 1, 0);
      tbl[5]  = mk(1, 0, 16'h1234, 8'h00, 0,  0, 8'h00, 0, 0);
      tbl[6]  = mk(0, 0, 16'h0000, 8'h00, 1,  0, 8'h34, 1, 0);
      tbl[7]  = mk(0, 0, 16'h0000, 8'h00, 1,  0, 8'h34, 1, 0);
      tbl[8]  = mk(0, 0, 16'h0000, 8'h00, 1,  0, 8'h34, 1, 0);
      tbl[9]  = mk(0, 0, 16'h0000, 8'h00, 1,  0, 8'h34, 1, 0);
      tbl[10] = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'h34, 1, 0);
      tbl[11] = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'h12, 1, 0);
      tbl[12] = mk(1, 1, 16'hC3D4, 8'h77, 0,  0, 8'h00, 0, 0);
      tbl[13] = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'hD4, 1, 1);
      tbl[14] = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'hC3, 1, 0);
      tbl[15] = mk(1, 0, 16'h5678, 8'h00, 0,  0, 8'h00, 0, 0);
      tbl[16] = mk(0, 1, 16'h0000, 8'h99, 0,  1, 8'h78, 1, 0);
      tbl[17] = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'h56, 1, 1);
      tbl[18] = mk(1, 0, 16'h9ABC, 8'h00, 0,  0, 8'h00, 0, 0);
      tbl[19] = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'hBC, 1, 0);
      tbl[20] = mk(0, 1, 16'h0000, 8'h11, 0,  1, 8'h9A, 1, 0);
      tbl[21] = mk(0, 1, 16'h0000, 8'hE1, 0,  0, 8'h00, 0, 1);
      tbl[22] = mk(1, 0, 16'hFFFF, 8'h00, 1,  0, 8'hE1, 1, 0);
      tbl[23] = mk(0, 0, 16'h0000, 8'h00, 1,  0, 8'hE1, 1, 1);
      tbl[24] = mk(0, 0, 16'h0000, 8'h00, 0,  1, 8'hE1, 1, 0);
      tbl[25] = mk(0, 0, 16'h0000, 8'h00, 1,  0, 8'h00, 0, 0);

      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         out_valid = tbl[i].ov; rddata_valid = tbl[i].rv;
         alu_out   = tbl[i].alu; rddata = tbl[i].rd; fifo_full = tbl[i].ff;
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), tbl[i].e_inc, tbl[i].e_data, tbl[i].e_busy, tbl[i].e_drop);
         @(posedge clk); #1;
      end

      // Reset in the first byte cycle of a 16'hBEEF transfer.
      idle_inputs();
      out_valid = 1'b1; alu_out = 16'hBEEF;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk_all("rst_lo_byte", 1'b1, 8'hEF, 1'b1, 1'b0);
      #1 reset = 1'b0;
      #1 chk_all("rst_async", 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all("rst_held", 1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk_all($sformatf("post_rst%0d", c), 1'b0, 8'h00, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      rddata_valid = 1'b1; rddata = 8'h5A;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk_all("post_rst_rd", 1'b1, 8'h5A, 1'b1, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_all("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

endmodule
